inst_sequencer: RTL and testbench

Instruction fetch-and-issue controller that sequences the single-cycle `cpu` datapath. It fetches 32-bit instructions from an instruction memory over a req/ack handshake and presents each one to the cpu's `Inst` input for exactly one issue cycle. It also gates register-file writes and stops on a HALT opcode, an external halt request or a fetch timeout. It sits between the instruction memory and `cpu`, replacing bench-driven `Inst` stimulus.

---
 rtl/inst_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_inst_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// ---------------------------------------------------------------------------
// inst_sequencer
//
// Fetch-and-issue controller for the single-cycle cpu datapath. It fetches one
// 32-bit instruction at a time from an instruction memory over a req/ack
// handshake. Each fetched word is presented to the cpu for exactly one issue
// cycle. The block gates register-file writes by opcode and stops on a HALT
// opcode, on an external halt request or on a fetch timeout.
//
// Parameters
//   ADDR_WIDTH : width of the word-addressed program counter
//   RESET_PC   : pc loaded on reset and on every accepted start
//   TIMEOUT    : unacknowledged request cycles tolerated before ERROR (1..255)
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : begin execution from RESET_PC (only in IDLE/HALTED/ERROR)
//   halt_req    : level; stop after the instruction currently in flight
//   imem_req    : fetch request, held high until acknowledged
//   imem_addr   : fetch word address, equal to pc
//   imem_ack    : read data valid this cycle (only looked at in FETCH)
//   imem_rdata  : instruction word, captured when imem_ack=1 in FETCH
//   inst        : instruction to the cpu, holds its value between issues
//   inst_valid  : one-cycle pulse while an instruction is issued
//   rf_we       : register-file write enable for the issued instruction
//   pc          : address of the next fetch
//   busy        : high in FETCH or ISSUE
//   halted      : high in HALTED
//   err         : high in ERROR
//   illegal     : sticky flag, an unsupported opcode has been issued
//
// Every output is either a register or decoded from registered state only,
// so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module inst_sequencer #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  err,
  output logic                  illegal
);

  // State encoding, kept as plain constants for compatibility with older tools.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_HALTED = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  // Opcodes recognised in inst[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [7:0]            TO_LIMIT = 8'(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

  logic [2:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] pc_q,      pc_d;
  logic [31:0]           inst_q,    inst_d;
  logic [7:0]            tcnt_q,    tcnt_d;
  logic                  illegal_q, illegal_d;
  // Remembers a halt request seen while a fetch was still outstanding, so a
  // single-cycle halt_req pulse during FETCH still stops after the issue.
  logic                  hpend_q,   hpend_d;

  logic [5:0] opcode;
  logic       op_write;
  logic       op_halt;

  assign opcode   = inst_q[31:26];
  assign op_write = (opcode == OP_RTYPE) || (opcode == OP_ADDI);
  assign op_halt  = (opcode == OP_HALT);

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    tcnt_d    = tcnt_q;
    illegal_d = illegal_q;
    hpend_d   = hpend_q;

    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = RESET_PC;
          tcnt_d    = 8'd0;
          illegal_d = 1'b0;
          hpend_d   = 1'b0;
        end else begin
          state_d   = state_q;
        end
      end

      S_FETCH: begin
        if (halt_req) begin
          hpend_d = 1'b1;
        end else begin
          hpend_d = hpend_q;
        end
        // An ack on the last allowed cycle wins over the timeout.
        if (imem_ack) begin
          inst_d  = imem_rdata;
          pc_d    = pc_q + PC_ONE;
          tcnt_d  = 8'd0;
          state_d = S_ISSUE;
        end else if ((tcnt_q + 8'd1) == TO_LIMIT) begin
          tcnt_d  = 8'd0;
          state_d = S_ERROR;
        end else begin
          tcnt_d  = tcnt_q + 8'd1;
        end
      end

      S_ISSUE: begin
        if (!op_write && !op_halt) begin
          illegal_d = 1'b1;
        end else begin
          illegal_d = illegal_q;
        end
        if (op_halt || halt_req || hpend_q) begin
          state_d = S_HALTED;
          hpend_d = 1'b0;
        end else begin
          state_d = S_FETCH;
          tcnt_d  = 8'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      tcnt_q    <= 8'd0;
      illegal_q <= 1'b0;
      hpend_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      tcnt_q    <= tcnt_d;
      illegal_q <= illegal_d;
      hpend_q   <= hpend_d;
    end
  end

  // Output decode from registered state; reset forces all of these at once.
  always_comb begin
    imem_req   = (state_q == S_FETCH);
    imem_addr  = pc_q;
    inst       = inst_q;
    inst_valid = (state_q == S_ISSUE);
    rf_we      = (state_q == S_ISSUE) && op_write;
    pc         = pc_q;
    busy       = (state_q == S_FETCH) || (state_q == S_ISSUE);
    halted     = (state_q == S_HALTED);
    err        = (state_q == S_ERROR);
    illegal    = illegal_q;
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inst_sequencer
//
// Directed bench for inst_sequencer. Instance A (ADDR_WIDTH=8, TIMEOUT=15) is
// served by a memory responder with a programmable ack delay and runs the
// program, delayed-ack, timeout, halt_req and illegal-opcode scenarios. A tiny
// register-file model of the cpu tracks $1. Instance B (ADDR_WIDTH=2) checks
// pc wrap-around and asynchronous reset in the middle of a fetch.
// ---------------------------------------------------------------------------
module tb_inst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic        rst_n = 1'b0, start = 1'b0, halt_req = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [7:0]  imem_addr, pc;
  logic [31:0] imem_rdata = 32'd0, inst;
  logic        inst_valid, rf_we, busy, halted, err, illegal;

  inst_sequencer #(.ADDR_WIDTH(8), .RESET_PC(8'd0), .TIMEOUT(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted), .err(err),
    .illegal(illegal)
  );

  logic [31:0] mem [0:15];
  int          ack_delay = 0;
  bit          never_ack = 1'b0;
  int          wcnt = 0;

  // Memory responder: acks after ack_delay waiting cycles of imem_req.
  always @(negedge clk) begin
    if (!imem_req) begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end else if (!never_ack && wcnt == ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[imem_addr[3:0]];
    end else begin
      imem_ack = 1'b0;
      wcnt++;
    end
  end

  // ---------------- instance B (pc wrap / reset) ----------------
  logic        rst_n_b = 1'b0, start_b = 1'b0;
  logic        req_b, ack_b = 1'b0, force_ack_b = 1'b0;
  logic [1:0]  addr_b, pc_b;
  logic [31:0] inst_b;
  logic        valid_b, we_b, busy_b, halted_b, err_b, illegal_b;

  inst_sequencer #(.ADDR_WIDTH(2), .RESET_PC(2'd0), .TIMEOUT(15)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .halt_req(1'b0),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack_b),
    .imem_rdata(32'h0000_0820), .inst(inst_b), .inst_valid(valid_b),
    .rf_we(we_b), .pc(pc_b), .busy(busy_b), .halted(halted_b), .err(err_b),
    .illegal(illegal_b)
  );

  always @(negedge clk) ack_b = req_b | force_ack_b;

  // ---------------- cpu register model and run bookkeeping ----------------
  logic [31:0] rf [0:31];
  int          icyc [0:15];
  logic [31:0] iinst [0:15];
  logic        iwe [0:15];
  logic        iill [0:15];
  int          ni;
  int          cyc = 0;
  int          req_rise_cyc, err_cyc, req_cycles;
  int          halt_at_addr = -1;
  bit          saw_addr2;

  task automatic clear_rf();
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
  endtask

  // Runs instance A until halted/err, recording issues and updating the model.
  task automatic run(input int budget);
    logic       prev_req;
    logic [7:0] prev_addr;
    bit         done;
    ni = 0; prev_req = 1'b0; prev_addr = 8'd0; saw_addr2 = 1'b0; done = 1'b0;
    req_rise_cyc = -1; err_cyc = -1; req_cycles = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      cyc++;
      if (start) start = 1'b0;
      if (halt_req) halt_req = 1'b0;
      if (imem_req && prev_req) check_eq("addr_stable", {24'd0, imem_addr}, {24'd0, prev_addr});
      if (imem_req && !prev_req && req_rise_cyc < 0) req_rise_cyc = cyc;
      if (imem_req) req_cycles++;
      if (imem_req && imem_addr == 8'd2) saw_addr2 = 1'b1;
      if (imem_req && halt_at_addr == int'(imem_addr)) begin
        halt_req     = 1'b1;
        halt_at_addr = -1;
      end
      if (inst_valid && ni < 16) begin
        icyc[ni] = cyc; iinst[ni] = inst; iwe[ni] = rf_we; iill[ni] = illegal;
        ni++;
        if (rf_we) begin
          if (inst[31:26] == 6'b000000 && inst[5:0] == 6'h20)
            rf[inst[15:11]] = rf[inst[25:21]] + rf[inst[20:16]];
          else if (inst[31:26] == 6'b010000)
            rf[inst[20:16]] = rf[inst[25:21]] + {{16{inst[15]}}, inst[15:0]};
          rf[0] = 32'd0;
        end
      end
      prev_req = imem_req; prev_addr = imem_addr;
      if (err && err_cyc < 0) err_cyc = cyc;
      if (halted || err) done = 1'b1;
    end
    check_eq("run_terminated", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0820;
    mem[0] = 32'h0000_0820;
    mem[1] = 32'h4001_0001;
    mem[2] = 32'h0021_0820;
    mem[3] = 32'hFC00_0000;
  endtask

  initial begin
    load_prog();
    clear_rf();

    // Reset values of instance A.
    #3;
    check_eq("rst_req",    {31'd0, imem_req},   32'd0);
    check_eq("rst_addr",   {24'd0, imem_addr},  32'd0);
    check_eq("rst_inst",   inst,                32'd0);
    check_eq("rst_flags",  {26'd0, inst_valid, rf_we, busy, halted, err, illegal}, 32'd0);
    check_eq("rst_pc",     {24'd0, pc},         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    check_eq("idle_after_rst", {30'd0, busy, imem_req}, 32'd0);

    // Program with same-cycle ack.
    pulse_start();
    run(100);
    check_eq("prog_issues", ni, 32'd4);
    check_eq("prog_gap1", icyc[1] - icyc[0], 32'd2);
    check_eq("prog_gap2", icyc[2] - icyc[1], 32'd2);
    check_eq("prog_gap3", icyc[3] - icyc[2], 32'd2);
    check_eq("prog_we", {28'd0, iwe[0], iwe[1], iwe[2], iwe[3]}, 32'b1110);
    check_eq("prog_inst3", iinst[3], 32'hFC00_0000);
    check_eq("prog_r1", rf[1], 32'd2);
    check_eq("prog_halted", {31'd0, halted}, 32'd1);
    check_eq("prog_pc", {24'd0, pc}, 32'd4);
    check_eq("prog_not_busy", {31'd0, busy}, 32'd0);

    // Same program, ack delayed 3 cycles on every fetch.
    clear_rf();
    ack_delay = 3;
    pulse_start();
    run(200);
    check_eq("dly_issues", ni, 32'd4);
    check_eq("dly_gap1", icyc[1] - icyc[0], 32'd5);
    check_eq("dly_gap3", icyc[3] - icyc[2], 32'd5);
    check_eq("dly_r1", rf[1], 32'd2);
    check_eq("dly_pc", {24'd0, pc}, 32'd4);
    ack_delay = 0;

    // Never ack: ERROR after exactly 15 request cycles.
    never_ack = 1'b1;
    pulse_start();
    run(100);
    check_eq("to_err", {31'd0, err}, 32'd1);
    check_eq("to_req_low", {31'd0, imem_req}, 32'd0);
    check_eq("to_req_cycles", req_cycles, 32'd15);
    check_eq("to_latency", err_cyc - req_rise_cyc, 32'd15);
    check_eq("to_no_issue", ni, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("to_pc_frozen", {24'd0, pc}, 32'd0);
    never_ack = 1'b0;
    pulse_start();
    @(negedge clk);
    start = 1'b0;
    check_eq("to_restart_req", {31'd0, imem_req}, 32'd1);
    check_eq("to_restart_addr", {24'd0, imem_addr}, 32'd0);
    check_eq("to_restart_err", {31'd0, err}, 32'd0);
    clear_rf();
    run(100);
    check_eq("to_restart_halt", {24'd0, pc}, 32'd4);

    // halt_req coincident with the ack of word 1.
    clear_rf();
    halt_at_addr = 1;
    pulse_start();
    run(100);
    check_eq("hr_issues", ni, 32'd2);
    check_eq("hr_inst1", iinst[1], 32'h4001_0001);
    check_eq("hr_halted", {31'd0, halted}, 32'd1);
    check_eq("hr_pc", {24'd0, pc}, 32'd2);
    check_eq("hr_no_fetch2", {31'd0, saw_addr2}, 32'd0);

    // Illegal opcode is issued without write, flag sticks, execution continues.
    mem[0] = 32'hA400_0000;
    mem[1] = 32'h0000_0820;
    mem[2] = 32'hFC00_0000;
    clear_rf();
    pulse_start();
    run(100);
    check_eq("ill_issues", ni, 32'd3);
    check_eq("ill_we0", {31'd0, iwe[0]}, 32'd0);
    check_eq("ill_we1", {31'd0, iwe[1]}, 32'd1);
    check_eq("ill_flag_mid", {31'd0, iill[1]}, 32'd1);
    check_eq("ill_sticky", {31'd0, illegal}, 32'd1);
    check_eq("ill_halted", {31'd0, halted}, 32'd1);
    pulse_start();
    @(negedge clk);
    start = 1'b0;
    check_eq("ill_cleared", {31'd0, illegal}, 32'd0);
    run(100);

    // Instance B: pc wraps 3 -> 0 with ADDR_WIDTH=2.
    begin
      int nb;
      bit stopped;
      nb = 0;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int n = 0; n < 40 && nb < 4; n++) begin
        @(negedge clk);
        if (valid_b) begin
          check_eq("wrap_pc", {30'd0, pc_b}, (nb + 1) % 4);
          nb++;
        end
      end
      check_eq("wrap_count", nb, 32'd4);
      stopped = 1'b0;
      for (int n = 0; n < 20 && !stopped; n++) begin
        @(negedge clk);
        if (req_b && pc_b == 2'd1) stopped = 1'b1;
      end
      check_eq("b_fetch_addr1", {31'd0, stopped}, 32'd1);
      check_eq("b_inst_before", inst_b, 32'h0000_0820);
      // Asynchronous reset in the middle of the FETCH cycle.
      #2;
      rst_n_b = 1'b0;
      #1;
      check_eq("arst_req",   {31'd0, req_b}, 32'd0);
      check_eq("arst_pc",    {30'd0, pc_b},  32'd0);
      check_eq("arst_addr",  {30'd0, addr_b}, 32'd0);
      check_eq("arst_inst",  inst_b,          32'd0);
      check_eq("arst_flags", {26'd0, valid_b, we_b, busy_b, halted_b, err_b, illegal_b}, 32'd0);
      // A late ack around reset release must not start a fetch.
      force_ack_b = 1'b1;
      @(negedge clk);
      rst_n_b = 1'b1;
      @(negedge clk);
      @(negedge clk);
      force_ack_b = 1'b0;
      check_eq("late_ack_busy", {31'd0, busy_b}, 32'd0);
      check_eq("late_ack_inst", inst_b, 32'd0);
      check_eq("late_ack_pc", {30'd0, pc_b}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
